// File: rtl/mod_control_contador.sv
// Gated pulse counter controller: drives an external wrapping counter over a fixed
// window, tracks its wraps and publishes the total count with an overflow flag.
module mod_control_contador #(
    parameter int VENTANA    = 1000,
    parameter int MAX_CUENTA = 20
) (
    input  logic       CLK_cont,
    input  logic       Reset,
    input  logic       Inicio,
    input  logic       Parar,
    input  logic       Pulso_in,
    input  logic [4:0] Cuenta,
    output logic       Cont_clr,
    output logic       Cont_inc,
    output logic       Ocupado,
    output logic       Listo,
    output logic [9:0] Resultado,
    output logic       Desborde
);

    localparam logic [15:0] TIMER_ULTIMO = 16'(VENTANA - 1);
    localparam logic [9:0]  MODULO       = 10'(MAX_CUENTA + 1);
    localparam logic [4:0]  CUENTA_TOPE  = 5'(MAX_CUENTA);
    localparam logic [4:0]  VUELTAS_MAX  = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        SETTLE,
        LATCH
    } estado_t;

    estado_t     estado;
    estado_t     estado_sig;

    logic        sync_p0;
    logic        sync_p1;
    logic        sync_p2;
    logic        flanco;
    logic        vuelta;
    logic [15:0] timer;
    logic [4:0]  vueltas;
    logic        desborde_int;

    function automatic logic [9:0] total_saturado(input logic       ovf,
                                                  input logic [4:0] v,
                                                  input logic [4:0] c);
        logic [9:0] total;
        total = 10'(v) * MODULO + 10'(c);
        return ovf ? 10'h3FF : total;
    endfunction

    // Stage p0/p1: two-flop synchronizer; p2: history register for rising-edge detection
    always_ff @(posedge CLK_cont) begin
        if (!Reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= Pulso_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign flanco = sync_p1 & ~sync_p2;
    assign vuelta = Cont_inc && (Cuenta == CUENTA_TOPE);

    always_ff @(posedge CLK_cont) begin
        if (!Reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        unique case (estado)
            IDLE:    if (Inicio) estado_sig = CLEAR;
            CLEAR:   estado_sig = Parar ? IDLE : COUNT;
            COUNT: begin
                if (Parar)                       estado_sig = IDLE;
                else if (timer == TIMER_ULTIMO)  estado_sig = SETTLE;
            end
            SETTLE:  estado_sig = Parar ? IDLE : LATCH;
            LATCH:   estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    assign Ocupado = (estado != IDLE);

    // Commands are registered so the external counter sees clean, glitch-free enables
    always_ff @(posedge CLK_cont) begin
        if (!Reset) begin
            Cont_clr <= 1'b0;
            Cont_inc <= 1'b0;
            Listo    <= 1'b0;
        end else begin
            Cont_clr <= (estado_sig == CLEAR);
            Cont_inc <= (estado == COUNT) && (estado_sig != IDLE) && flanco;
            Listo    <= (estado == LATCH);
        end
    end

    always_ff @(posedge CLK_cont) begin
        if (!Reset) begin
            timer        <= '0;
            vueltas      <= '0;
            desborde_int <= 1'b0;
        end else if (estado == CLEAR) begin
            timer        <= '0;
            vueltas      <= '0;
            desborde_int <= 1'b0;
        end else begin
            if (estado == COUNT) begin
                timer <= timer + 16'd1;
            end
            if (vuelta) begin
                if (vueltas == VUELTAS_MAX) desborde_int <= 1'b1;
                else                        vueltas      <= vueltas + 5'd1;
            end
        end
    end

    // Result is captured together with Listo, so it is valid while Listo is high
    always_ff @(posedge CLK_cont) begin
        if (!Reset) begin
            Resultado <= '0;
            Desborde  <= 1'b0;
        end else if (estado == LATCH) begin
            Resultado <= total_saturado(desborde_int, vueltas, Cuenta);
            Desborde  <= desborde_int;
        end
    end

endmodule

// File: tb/tb_mod_control_contador.sv
// Directed bench for mod_control_contador with a behavioural model of the external
// wrapping counter; one short-window instance and one long-window instance.
module tb_mod_control_contador;

    localparam int MAXC = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sel = 1'b0;

    logic       inicio_a = 1'b0, parar_a = 1'b0, pulso_a = 1'b0;
    logic [4:0] cuenta_a = '0;
    logic       clr_a, inc_a, ocu_a, listo_a, desb_a;
    logic [9:0] res_a;

    logic       inicio_b = 1'b0, parar_b = 1'b0, pulso_b = 1'b0;
    logic [4:0] cuenta_b = '0;
    logic       clr_b, inc_b, ocu_b, listo_b, desb_b;
    logic [9:0] res_b;

    int n_vec = 0;
    int n_err = 0;
    int t_listo, t_last, n_listo;
    logic inc_settle;

    wire       lst = sel ? listo_b : listo_a;
    wire       ocu = sel ? ocu_b : ocu_a;
    wire       clr = sel ? clr_b : clr_a;
    wire       inc = sel ? inc_b : inc_a;

    always #5 clk = ~clk;

    mod_control_contador #(.VENTANA(100), .MAX_CUENTA(MAXC)) dut_a (
        .CLK_cont (clk),
        .Reset    (reset),
        .Inicio   (inicio_a),
        .Parar    (parar_a),
        .Pulso_in (pulso_a),
        .Cuenta   (cuenta_a),
        .Cont_clr (clr_a),
        .Cont_inc (inc_a),
        .Ocupado  (ocu_a),
        .Listo    (listo_a),
        .Resultado(res_a),
        .Desborde (desb_a)
    );

    mod_control_contador #(.VENTANA(2000), .MAX_CUENTA(MAXC)) dut_b (
        .CLK_cont (clk),
        .Reset    (reset),
        .Inicio   (inicio_b),
        .Parar    (parar_b),
        .Pulso_in (pulso_b),
        .Cuenta   (cuenta_b),
        .Cont_clr (clr_b),
        .Cont_inc (inc_b),
        .Ocupado  (ocu_b),
        .Listo    (listo_b),
        .Resultado(res_b),
        .Desborde (desb_b)
    );

    // External wrapping counters 0..MAXC driven by the commands
    always @(posedge clk) begin
        if (clr_a)      cuenta_a <= '0;
        else if (inc_a) cuenta_a <= (cuenta_a == 5'(MAXC)) ? 5'd0 : cuenta_a + 5'd1;
        if (clr_b)      cuenta_b <= '0;
        else if (inc_b) cuenta_b <= (cuenta_b == 5'(MAXC)) ? 5'd0 : cuenta_b + 5'd1;
    end

    task automatic comprobar(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle c counts from the edge that samples Inicio (cycle 0 = CLEAR).
    task automatic run(input bit s, input int npul, input int per, input int first,
                       input int parar_at, input int reset_at, input bit pi,
                       input bit hold, input int ciclos);
        int  vent;
        int  k;
        logic p;
        vent = s ? 2000 : 100;
        t_listo = -1; t_last = -1; n_listo = 0; inc_settle = 1'b0;
        @(negedge clk);
        sel = s;
        if (s) inicio_b = 1'b1; else inicio_a = 1'b1;
        parar_a = pi;
        @(posedge clk);
        for (int c = 0; c < ciclos; c++) begin
            @(negedge clk);
            if (lst) begin
                n_listo++;
                if (t_listo < 0) t_listo = c;
                t_last = c;
            end
            if (c == 0) begin
                comprobar("ocupado_c0", int'(ocu), 1);
                comprobar("clr_c0", int'(clr), 1);
            end
            if (c == 1) comprobar("clr_c1", int'(clr), 0);
            if (c == vent + 1) inc_settle = inc;
            if (parar_at >= 0 && c == parar_at + 1) begin
                comprobar("parar_ocupado", int'(ocu), 0);
                comprobar("parar_inc", int'(inc), 0);
            end
            if (reset_at >= 0 && c == reset_at + 1) begin
                comprobar("rst_ocupado", int'(ocu), 0);
                comprobar("rst_inc", int'(inc), 0);
            end
            k = c - first;
            p = 1'b0;
            if (npul > 0 && k >= 0 && k < npul * per) p = ((k % per) < per / 2);
            if (s) begin
                inicio_b = hold && (c < ciclos - 1);
                pulso_b  = p;
            end else begin
                inicio_a = hold && (c < ciclos - 1);
                pulso_a  = p;
            end
            parar_a = (c == parar_at);
            reset   = (c != reset_at);
        end
        @(negedge clk);
        pulso_a = 1'b0; pulso_b = 1'b0; inicio_a = 1'b0; inicio_b = 1'b0;
        parar_a = 1'b0; reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        comprobar("rst_clr", int'(clr_a), 0);
        comprobar("rst_inc", int'(inc_a), 0);
        comprobar("rst_ocupado", int'(ocu_a), 0);
        comprobar("rst_listo", int'(listo_a), 0);
        comprobar("rst_resultado", int'(res_a), 0);
        comprobar("rst_desborde", int'(desb_a), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 5 pulses, period 10
        run(0, 5, 10, 5, -1, -1, 0, 0, 110);
        comprobar("t1_latencia", t_listo, 103);
        comprobar("t1_nlisto", n_listo, 1);
        comprobar("t1_resultado", int'(res_a), 5);
        comprobar("t1_desborde", int'(desb_a), 0);

        // 25 pulses, period 4: one wrap, counter left at 4
        run(0, 25, 4, 2, -1, -1, 0, 0, 110);
        comprobar("t2_cuenta", int'(cuenta_a), 4);
        comprobar("t2_resultado", int'(res_a), 25);
        comprobar("t2_nlisto", n_listo, 1);

        // 21st edge detected in the final COUNT cycle with Cuenta=20
        run(0, 21, 4, 18, -1, -1, 0, 0, 110);
        comprobar("t3_inc_settle", int'(inc_settle), 1);
        comprobar("t3_resultado", int'(res_a), 21);

        // Edge detected in SETTLE is discarded
        run(0, 5, 10, 59, -1, -1, 0, 0, 110);
        comprobar("t4_inc_settle", int'(inc_settle), 0);
        comprobar("t4_resultado", int'(res_a), 4);

        // Reset mid-COUNT aborts, then a clean 7-pulse window
        run(0, 7, 10, 5, -1, 40, 0, 0, 120);
        comprobar("t5_nlisto", n_listo, 0);
        comprobar("t5_resultado", int'(res_a), 0);
        run(0, 7, 10, 5, -1, -1, 0, 0, 110);
        comprobar("t6_resultado", int'(res_a), 7);
        comprobar("t6_nlisto", n_listo, 1);

        // Parar in COUNT cycle 50
        run(0, 7, 10, 8, 50, -1, 0, 0, 120);
        comprobar("t7_nlisto", n_listo, 0);
        comprobar("t7_resultado", int'(res_a), 7);
        comprobar("t7_desborde", int'(desb_a), 0);

        // Parar together with Inicio in IDLE: Inicio wins
        run(0, 3, 10, 5, -1, -1, 1, 0, 110);
        comprobar("t8_nlisto", n_listo, 1);
        comprobar("t8_latencia", t_listo, 103);
        comprobar("t8_resultado", int'(res_a), 3);

        // Inicio held high: back-to-back windows every 104 cycles
        run(0, 0, 1, 0, -1, -1, 0, 1, 312);
        comprobar("t9_nlisto", n_listo, 3);
        comprobar("t9_primero", t_listo, 103);
        comprobar("t9_ultimo", t_last, 311);
        comprobar("t9_resultado", int'(res_a), 0);
        comprobar("t9_ocupado_fin", int'(ocu_a), 0);

        // Long window, period 2: overflow saturates
        run(1, 1000, 2, 0, -1, -1, 0, 0, 2010);
        comprobar("t10_latencia", t_listo, 2003);
        comprobar("t10_resultado", int'(res_b), 10'h3FF);
        comprobar("t10_desborde", int'(desb_b), 1);
        comprobar("t10_resultado_a", int'(res_a), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
